// File: rtl/cp0_nested_int_ctrl.sv
// CP0 with prioritised maskable interrupts, a nested {Status,EPC} save stack and
// per-cause handler vectors; serves mfc0/mtc0 from the ID stage.
module cp0_nested_int_ctrl #(
  parameter int          NUM_IRQ     = 4,
  parameter int          STACK_DEPTH = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0008,
  parameter logic [31:0] VEC_STRIDE  = 32'd4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_ov,
  input  logic               exc_ri,
  input  logic               syscall,
  input  logic               eret,
  input  logic               cr_read,
  input  logic               cr_write,
  input  logic [4:0]         cr_addr,
  input  logic [31:0]        cr_wdata,
  input  logic [31:0]        pc_plus4,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        cr_rdata,
  output logic               rdata_valid,
  output logic               ie,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               flush_ex_mem,
  output logic               flush_mem_wb
);

  localparam int            SW         = NUM_IRQ + 1;
  localparam int            DW         = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [4:0] ADDR_DEPTH  = 5'd15;

  typedef enum logic [1:0] {
    CODE_INT = 2'd0,
    CODE_SYS = 2'd1,
    CODE_RI  = 2'd2,
    CODE_OV  = 2'd3
  } code_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_OV,
    ACT_RI,
    ACT_SYS,
    ACT_ERET,
    ACT_IRQ,
    ACT_WRITE,
    ACT_READ
  } act_e;

  logic [SW-1:0] status;
  code_e         cause_code;
  logic          novf;
  logic [DW-1:0] depth;
  logic [SW-1:0] stk_status [STACK_DEPTH];
  logic [31:0]   stk_epc    [STACK_DEPTH];

  logic [NUM_IRQ-1:0] pending;
  logic               stack_empty;
  logic               stack_full;
  logic [DW-1:0]      top_idx;
  logic [DW-1:0]      push_idx;
  logic [SW-1:0]      top_status;
  logic [31:0]        top_epc;
  logic               irq_eligible;
  logic [3:0]         irq_line;
  act_e               act;
  logic               take;
  code_e              take_code;
  logic [3:0]         vec_idx;
  logic [31:0]        take_epc;
  logic [31:0]        vec_pc;
  logic [31:0]        read_val;

  assign pending     = irq & status[NUM_IRQ:1];
  assign stack_empty = (depth == '0);
  assign stack_full  = (depth == FULL_DEPTH);
  assign top_idx     = depth - DW'(1);
  // At full depth a synchronous event overwrites the top entry instead of pushing.
  assign push_idx    = stack_full ? top_idx : depth;
  assign ie          = status[0];

  always_comb begin
    top_status = '0;
    top_epc    = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!stack_empty && DW'(i) == top_idx) begin
        top_status = stk_status[i];
        top_epc    = stk_epc[i];
      end
    end
  end

  // Scan downwards so the lowest pending index wins.
  always_comb begin
    irq_line = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) irq_line = 4'(i);
    end
  end

  assign irq_eligible = status[0] && (|pending) && !stack_full;

  always_comb begin
    if (exc_ov)            act = ACT_OV;
    else if (exc_ri)       act = ACT_RI;
    else if (syscall)      act = ACT_SYS;
    else if (eret)         act = ACT_ERET;
    else if (irq_eligible) act = ACT_IRQ;
    else if (cr_write)     act = ACT_WRITE;
    else if (cr_read)      act = ACT_READ;
    else                   act = ACT_NONE;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    take      = 1'b1;
    take_code = CODE_INT;
    vec_idx   = 4'd4 + irq_line;
    take_epc  = pc_plus4 - 32'd4;
    case (act)
      ACT_OV: begin
        take_code = CODE_OV;
        vec_idx   = 4'd3;
        take_epc  = pc_plus4 - 32'd8;
      end
      ACT_RI: begin
        take_code = CODE_RI;
        vec_idx   = 4'd2;
        take_epc  = pc_plus4 - 32'd8;
      end
      ACT_SYS: begin
        take_code = CODE_SYS;
        vec_idx   = 4'd1;
      end
      ACT_IRQ: ;
      default: take = 1'b0;
    endcase
  end

  assign vec_pc = VEC_BASE + 32'(vec_idx) * VEC_STRIDE;

  always_comb begin
    read_val = '0;
    case (cr_addr)
      ADDR_STATUS: read_val = 32'(status);
      ADDR_CAUSE:  read_val = 32'({pending, 5'b0, novf, cause_code});
      ADDR_EPC:    read_val = top_epc;
      ADDR_DEPTH:  read_val = 32'(depth);
      default:     ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status       <= '0;
      cause_code   <= CODE_INT;
      novf         <= 1'b0;
      depth        <= '0;
      int_ack      <= '0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      cr_rdata     <= '0;
      rdata_valid  <= 1'b0;
      flush_if_id  <= 1'b0;
      flush_id_ex  <= 1'b0;
      flush_ex_mem <= 1'b0;
      flush_mem_wb <= 1'b0;
    end else begin
      int_ack      <= '0;
      redirect     <= 1'b0;
      cr_rdata     <= '0;
      rdata_valid  <= 1'b0;
      flush_if_id  <= 1'b0;
      flush_id_ex  <= 1'b0;
      flush_ex_mem <= 1'b0;
      flush_mem_wb <= 1'b0;

      if (take) begin
        status[0]   <= 1'b0;
        cause_code  <= take_code;
        redirect    <= 1'b1;
        redirect_pc <= vec_pc;
        flush_if_id <= 1'b1;
        flush_id_ex <= 1'b1;
        if (stack_full) novf  <= 1'b1;
        else            depth <= depth + DW'(1);
      end

      case (act)
        ACT_OV, ACT_RI: begin
          flush_ex_mem <= 1'b1;
          flush_mem_wb <= 1'b1;
        end
        ACT_IRQ: begin
          int_ack      <= NUM_IRQ'(1) << irq_line;
          flush_ex_mem <= cr_write;
        end
        ACT_ERET: begin
          if (!stack_empty) begin
            status      <= top_status;
            depth       <= depth - DW'(1);
            redirect    <= 1'b1;
            redirect_pc <= top_epc;
            flush_if_id <= 1'b1;
            flush_id_ex <= 1'b1;
          end
        end
        ACT_WRITE: begin
          case (cr_addr)
            ADDR_STATUS: status <= cr_wdata[SW-1:0];
            ADDR_CAUSE: begin
              cause_code <= code_e'(cr_wdata[1:0]);
              novf       <= cr_wdata[2];
            end
            default: ;
          endcase
        end
        ACT_READ: begin
          rdata_valid <= 1'b1;
          cr_rdata    <= read_val;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the save stack is cleared on reset so an eret can never restore stale state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_status[i] <= '0;
        stk_epc[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (take && DW'(i) == push_idx) begin
          stk_status[i] <= status;
          stk_epc[i]    <= take_epc;
        end else if (act == ACT_WRITE && cr_addr == ADDR_EPC && !stack_empty && DW'(i) == top_idx) begin
          stk_epc[i] <= cr_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_nested_int_ctrl.sv
// Bench for cp0_nested_int_ctrl: directed scenarios with constant expectations, then
// random traffic checked against a queue-based model of the CP0 rules.
module tb_cp0_nested_int_ctrl;

  localparam int          NI = 4;
  localparam int          SD = 2;
  localparam logic [31:0] VB = 32'h0000_0008;
  localparam logic [31:0] VS = 32'd4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NI-1:0] irq = '0;
  logic          exc_ov = 1'b0, exc_ri = 1'b0, syscall = 1'b0, eret = 1'b0;
  logic          cr_read = 1'b0, cr_write = 1'b0;
  logic [4:0]    cr_addr = '0;
  logic [31:0]   cr_wdata = '0, pc_plus4 = '0;
  logic [NI-1:0] int_ack;
  logic          redirect, rdata_valid, ie;
  logic [31:0]   redirect_pc, cr_rdata;
  logic          flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [3:0]    fl;

  assign fl = {flush_mem_wb, flush_ex_mem, flush_id_ex, flush_if_id};

  cp0_nested_int_ctrl #(.NUM_IRQ(NI), .STACK_DEPTH(SD), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .reset(reset), .irq(irq), .exc_ov(exc_ov), .exc_ri(exc_ri),
    .syscall(syscall), .eret(eret), .cr_read(cr_read), .cr_write(cr_write),
    .cr_addr(cr_addr), .cr_wdata(cr_wdata), .pc_plus4(pc_plus4), .int_ack(int_ack),
    .redirect(redirect), .redirect_pc(redirect_pc), .cr_rdata(cr_rdata),
    .rdata_valid(rdata_valid), .ie(ie), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the save stack is a queue of {Status, EPC} entries.
  typedef struct packed {
    logic [NI:0] st;
    logic [31:0] epc;
  } entry_t;

  entry_t      m_stack[$];
  logic [NI:0] m_status;
  logic [1:0]  m_code;
  logic        m_novf;

  logic [NI-1:0] e_int_ack;
  logic          e_redirect, e_valid;
  logic [31:0]   e_redirect_pc, e_rdata;
  logic [3:0]    e_flush;

  function automatic void m_take(input logic [1:0] code, input int idx, input logic [31:0] epc);
    entry_t en;
    en.st  = m_status;
    en.epc = epc;
    if (m_stack.size() == SD) begin
      m_stack[SD-1] = en;
      m_novf = 1'b1;
    end else begin
      m_stack.push_back(en);
    end
    m_status[0]   = 1'b0;
    m_code        = code;
    e_redirect    = 1'b1;
    e_redirect_pc = VB + 32'(idx) * VS;
    e_flush[1:0]  = 2'b11;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    int     d = m_stack.size();
    entry_t en;
    case (a)
      5'd12: return 32'(m_status);
      5'd13: return (32'(irq & m_status[NI:1]) << 8) | (32'(m_novf) << 2) | 32'(m_code);
      5'd14: begin
        if (d == 0) return 32'd0;
        en = m_stack[d-1];
        return en.epc;
      end
      5'd15: return 32'(d);
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step();
    logic [NI-1:0] pend = irq & m_status[NI:1];
    int            d = m_stack.size();
    int            k = -1;
    entry_t        en;
    e_int_ack = '0; e_redirect = 1'b0; e_redirect_pc = redirect_pc;
    e_valid = 1'b0; e_rdata = '0; e_flush = '0;
    for (int i = NI - 1; i >= 0; i--) if (pend[i]) k = i;
    if (exc_ov) begin
      m_take(2'd3, 3, pc_plus4 - 32'd8);
      e_flush[3:2] = 2'b11;
    end else if (exc_ri) begin
      m_take(2'd2, 2, pc_plus4 - 32'd8);
      e_flush[3:2] = 2'b11;
    end else if (syscall) begin
      m_take(2'd1, 1, pc_plus4 - 32'd4);
    end else if (eret) begin
      if (d > 0) begin
        en            = m_stack.pop_back();
        m_status      = en.st;
        e_redirect    = 1'b1;
        e_redirect_pc = en.epc;
        e_flush[1:0]  = 2'b11;
      end
    end else if (m_status[0] && k >= 0 && d < SD) begin
      m_take(2'd0, 4 + k, pc_plus4 - 32'd4);
      e_int_ack[k] = 1'b1;
      e_flush[2]   = cr_write;
    end else if (cr_write) begin
      case (cr_addr)
        5'd12: m_status = cr_wdata[NI:0];
        5'd13: begin m_code = cr_wdata[1:0]; m_novf = cr_wdata[2]; end
        5'd14: if (d > 0) begin en = m_stack[d-1]; en.epc = cr_wdata; m_stack[d-1] = en; end
        default: ;
      endcase
    end else if (cr_read) begin
      e_valid = 1'b1;
      e_rdata = m_read(cr_addr);
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    exc_ov = 1'b0; exc_ri = 1'b0; syscall = 1'b0; eret = 1'b0;
    cr_read = 1'b0; cr_write = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cr_write = 1'b1; cr_addr = a; cr_wdata = d;
    tick();
  endtask

  task automatic rd(input logic [4:0] a);
    cr_read = 1'b1; cr_addr = a;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    irq = '0; exc_ov = 1'b0; exc_ri = 1'b0; syscall = 1'b0; eret = 1'b0;
    cr_read = 1'b0; cr_write = 1'b0; cr_addr = '0; cr_wdata = '0; pc_plus4 = '0;
    m_stack.delete(); m_status = '0; m_code = '0; m_novf = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if ({int_ack, redirect, redirect_pc, cr_rdata, rdata_valid, ie, fl} !== '0) begin n_fail++; $display("FAIL reset_outputs: got ack=%b rd=%b pc=%h data=%h v=%b ie=%b fl=%b want all 0", int_ack, redirect, redirect_pc, cr_rdata, rdata_valid, ie, fl); end
    rd(5'd12);
    n_tests++; if (cr_rdata !== 32'd0 || rdata_valid !== 1'b1) begin n_fail++; $display("FAIL reset_status: got %h/%b want 0/1", cr_rdata, rdata_valid); end
    rd(5'd13);
    n_tests++; if (cr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_cause: got %h want 0", cr_rdata); end
    rd(5'd15);
    n_tests++; if (cr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_depth: got %h want 0", cr_rdata); end
  endtask

  task automatic test_nested_irq();
    do_reset();
    wr(5'd12, 32'h1F);
    n_tests++; if (ie !== 1'b1) begin n_fail++; $display("FAIL ie_set: got %b want 1", ie); end
    irq = 4'b0110; pc_plus4 = 32'h40;
    tick();
    n_tests++; if (int_ack !== 4'b0010 || redirect !== 1'b1 || redirect_pc !== 32'h1C) begin n_fail++; $display("FAIL irq1_take: got ack=%b rd=%b pc=%h want 0010/1/0000001c", int_ack, redirect, redirect_pc); end
    n_tests++; if (ie !== 1'b0 || fl !== 4'b0011) begin n_fail++; $display("FAIL irq1_side: got ie=%b fl=%b want 0/0011", ie, fl); end
    rd(5'd14);
    n_tests++; if (cr_rdata !== 32'h3C) begin n_fail++; $display("FAIL irq1_epc: got %h want 0000003c", cr_rdata); end
    rd(5'd15);
    n_tests++; if (cr_rdata !== 32'd1) begin n_fail++; $display("FAIL irq1_depth: got %h want 1", cr_rdata); end
    irq = '0;
    wr(5'd12, 32'h1F);
    irq = 4'b0001; pc_plus4 = 32'h80;
    tick();
    n_tests++; if (int_ack !== 4'b0001 || redirect_pc !== 32'h18) begin n_fail++; $display("FAIL irq0_nested: got ack=%b pc=%h want 0001/00000018", int_ack, redirect_pc); end
    rd(5'd15);
    n_tests++; if (cr_rdata !== 32'd2) begin n_fail++; $display("FAIL nested_depth: got %h want 2", cr_rdata); end
    wr(5'd12, 32'h1F);
    tick();
    n_tests++; if (redirect !== 1'b0 || int_ack !== 4'b0000) begin n_fail++; $display("FAIL full_no_take: got rd=%b ack=%b want 0/0000", redirect, int_ack); end
    rd(5'd13);
    n_tests++; if (cr_rdata !== 32'h100) begin n_fail++; $display("FAIL pending_live: got %h want 00000100", cr_rdata); end
  endtask

  task automatic test_eret();
    irq = '0;
    wr(5'd12, 32'h0);
    eret = 1'b1;
    tick();
    n_tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h7C || fl !== 4'b0011) begin n_fail++; $display("FAIL eret_inner: got rd=%b pc=%h fl=%b want 1/0000007c/0011", redirect, redirect_pc, fl); end
    rd(5'd12);
    n_tests++; if (cr_rdata !== 32'h1F) begin n_fail++; $display("FAIL eret_inner_status: got %h want 0000001f", cr_rdata); end
    wr(5'd12, 32'h0);
    eret = 1'b1;
    tick();
    n_tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h3C || ie !== 1'b1) begin n_fail++; $display("FAIL eret_outer: got rd=%b pc=%h ie=%b want 1/0000003c/1", redirect, redirect_pc, ie); end
    eret = 1'b1;
    tick();
    n_tests++; if (redirect !== 1'b0 || fl !== 4'b0000) begin n_fail++; $display("FAIL eret_empty: got rd=%b fl=%b want 0/0000", redirect, fl); end
    rd(5'd15);
    n_tests++; if (cr_rdata !== 32'd0) begin n_fail++; $display("FAIL eret_depth: got %h want 0", cr_rdata); end
  endtask

  task automatic test_exc_priority();
    do_reset();
    wr(5'd12, 32'h1F);
    exc_ov = 1'b1; syscall = 1'b1; irq = 4'b0001; pc_plus4 = 32'h200;
    tick();
    n_tests++; if (redirect_pc !== 32'h14 || fl !== 4'b1111 || int_ack !== 4'b0000) begin n_fail++; $display("FAIL ov_prio: got pc=%h fl=%b ack=%b want 00000014/1111/0000", redirect_pc, fl, int_ack); end
    irq = '0;
    rd(5'd13);
    n_tests++; if (cr_rdata !== 32'd3) begin n_fail++; $display("FAIL ov_cause: got %h want 3", cr_rdata); end
    rd(5'd14);
    n_tests++; if (cr_rdata !== 32'h1F8) begin n_fail++; $display("FAIL ov_epc: got %h want 000001f8", cr_rdata); end
    exc_ri = 1'b1; eret = 1'b1; pc_plus4 = 32'h300;
    tick();
    n_tests++; if (redirect_pc !== 32'h10 || fl !== 4'b1111) begin n_fail++; $display("FAIL ri_take: got pc=%h fl=%b want 00000010/1111", redirect_pc, fl); end
  endtask

  task automatic test_overflow();
    syscall = 1'b1; pc_plus4 = 32'h400;
    tick();
    n_tests++; if (redirect_pc !== 32'h0C || fl !== 4'b0011) begin n_fail++; $display("FAIL ovf_sys: got pc=%h fl=%b want 0000000c/0011", redirect_pc, fl); end
    rd(5'd15);
    n_tests++; if (cr_rdata !== 32'd2) begin n_fail++; $display("FAIL ovf_depth: got %h want 2", cr_rdata); end
    rd(5'd14);
    n_tests++; if (cr_rdata !== 32'h3FC) begin n_fail++; $display("FAIL ovf_epc: got %h want 000003fc", cr_rdata); end
    rd(5'd13);
    n_tests++; if (cr_rdata !== 32'h5) begin n_fail++; $display("FAIL ovf_cause: got %h want 5", cr_rdata); end
    eret = 1'b1;
    tick();
    eret = 1'b1;
    tick();
    n_tests++; if (redirect_pc !== 32'h1F8) begin n_fail++; $display("FAIL ovf_outer_kept: got %h want 000001f8", redirect_pc); end
  endtask

  task automatic test_cr_space();
    do_reset();
    wr(5'd14, 32'h100);
    n_tests++; if (redirect !== 1'b0 || fl !== 4'b0000) begin n_fail++; $display("FAIL mtc0_no_flush: got rd=%b fl=%b want 0/0000", redirect, fl); end
    rd(5'd14);
    n_tests++; if (cr_rdata !== 32'd0) begin n_fail++; $display("FAIL epc_empty: got %h want 0", cr_rdata); end
    wr(5'd15, 32'd5);
    rd(5'd15);
    n_tests++; if (cr_rdata !== 32'd0) begin n_fail++; $display("FAIL depth_ro: got %h want 0", cr_rdata); end
    rd(5'd7);
    n_tests++; if (cr_rdata !== 32'd0 || rdata_valid !== 1'b1) begin n_fail++; $display("FAIL unmapped: got %h/%b want 0/1", cr_rdata, rdata_valid); end
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13);
    n_tests++; if (cr_rdata !== 32'h7) begin n_fail++; $display("FAIL cause_mask: got %h want 7", cr_rdata); end
    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12);
    n_tests++; if (cr_rdata !== 32'h1F) begin n_fail++; $display("FAIL status_mask: got %h want 1f", cr_rdata); end
    tick();
    n_tests++; if (cr_rdata !== 32'd0 || rdata_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rdata: got %h/%b want 0/0", cr_rdata, rdata_valid); end
  endtask

  task automatic test_irq_with_write();
    do_reset();
    wr(5'd12, 32'h1F);
    irq = 4'b1000; pc_plus4 = 32'h60;
    cr_write = 1'b1; cr_addr = 5'd12; cr_wdata = 32'h0;
    tick();
    n_tests++; if (int_ack !== 4'b1000 || redirect_pc !== 32'h24 || fl !== 4'b0111) begin n_fail++; $display("FAIL irq_wr: got ack=%b pc=%h fl=%b want 1000/00000024/0111", int_ack, redirect_pc, fl); end
    rd(5'd12);
    n_tests++; if (cr_rdata !== 32'h1E) begin n_fail++; $display("FAIL irq_wr_dropped: got %h want 1e", cr_rdata); end
  endtask

  task automatic test_async_reset();
    do_reset();
    syscall = 1'b1; pc_plus4 = 32'h500;
    tick();
    n_tests++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL pre_reset_take: got %b want 1", redirect); end
    #1 reset = 1'b0;
    #1;
    n_tests++; if (redirect !== 1'b0 || redirect_pc !== 32'd0 || fl !== 4'b0000) begin n_fail++; $display("FAIL async_clear: got rd=%b pc=%h fl=%b want 0/0/0000", redirect, redirect_pc, fl); end
    do_reset();
    rd(5'd15);
    n_tests++; if (cr_rdata !== 32'd0) begin n_fail++; $display("FAIL async_depth: got %h want 0", cr_rdata); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      exc_ov   = ($urandom_range(0, 24) == 0);
      exc_ri   = ($urandom_range(0, 24) == 0);
      syscall  = ($urandom_range(0, 11) == 0);
      eret     = ($urandom_range(0, 5) == 0);
      cr_write = ($urandom_range(0, 3) == 0);
      cr_read  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) irq = NI'($urandom);
      case ($urandom_range(0, 5))
        0: cr_addr = 5'd12;
        1: cr_addr = 5'd13;
        2: cr_addr = 5'd14;
        3: cr_addr = 5'd15;
        default: cr_addr = 5'($urandom);
      endcase
      cr_wdata = $urandom;
      pc_plus4 = $urandom & 32'hFFFF_FFFC;
      tick();
      n_tests++; if (redirect !== e_redirect || (e_redirect && redirect_pc !== e_redirect_pc)) begin n_fail++; $display("FAIL rnd_redirect cyc %0d: got %b/%h want %b/%h", c, redirect, redirect_pc, e_redirect, e_redirect_pc); end
      n_tests++; if (int_ack !== e_int_ack) begin n_fail++; $display("FAIL rnd_ack cyc %0d: got %b want %b", c, int_ack, e_int_ack); end
      n_tests++; if (fl !== e_flush) begin n_fail++; $display("FAIL rnd_flush cyc %0d: got %b want %b", c, fl, e_flush); end
      n_tests++; if (rdata_valid !== e_valid || cr_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc %0d: got %b/%h want %b/%h", c, rdata_valid, cr_rdata, e_valid, e_rdata); end
      n_tests++; if (ie !== m_status[0]) begin n_fail++; $display("FAIL rnd_ie cyc %0d: got %b want %b", c, ie, m_status[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_nested_irq();
    test_eret();
    test_exc_priority();
    test_overflow();
    test_cr_space();
    test_irq_with_write();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
